// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the E-stage multiply/divide unit. The E-stage
// decoder imports the same op codes, so both sides agree on the encoding.
//   - 4-bit MDU op codes (MDU_NONE .. MFLO)
//   - FSM state type for mdu_ctrl
//   - predicates is_md_arith / is_md_any / is_md_mult
// ---------------------------------------------------------------------------
package mdu_pkg;

  localparam logic [3:0] MDU_NONE = 4'd0;
  localparam logic [3:0] MULT     = 4'd1;
  localparam logic [3:0] MULTU    = 4'd2;
  localparam logic [3:0] DIV      = 4'd3;
  localparam logic [3:0] DIVU     = 4'd4;
  localparam logic [3:0] MTHI     = 4'd5;
  localparam logic [3:0] MTLO     = 4'd6;
  localparam logic [3:0] MFHI     = 4'd7;
  localparam logic [3:0] MFLO     = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for several cycles.
  function automatic logic is_md_arith(input logic [3:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  // Any valid MDU op (arith, move-to or move-from).
  function automatic logic is_md_any(input logic [3:0] op);
    return (op != MDU_NONE) && (op <= MFLO);
  endfunction

  // Multiply ops; selects the shorter latency.
  function automatic logic is_md_mult(input logic [3:0] op);
    return (op == MULT) || (op == MULTU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// ---------------------------------------------------------------------------
// mdu_calc
// Purely combinational 64-bit result generator for the MDU.
// Ports:
//   op      in  4   MDU op code (only MULT/MULTU/DIV/DIVU produce new values)
//   rs, rt  in  32  operands (rs = multiplicand / dividend)
//   cur_hi  in  32  current architectural HI
//   cur_lo  in  32  current architectural LO
//   res_hi  out 32  resulting HI
//   res_lo  out 32  resulting LO
// Divide by zero leaves HI/LO at their current values; the signed overflow
// case 0x80000000 / -1 yields LO=0x80000000, HI=0.
// ---------------------------------------------------------------------------
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic [31:0]        safe_rt;
  logic signed [31:0] rs_s;
  logic signed [31:0] rt_s;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;

  // Sign-extending to 64 bits makes the low 64 bits of the product the
  // correct two's-complement signed product.
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  assign div_zero = (rt == 32'd0);
  assign div_ovf  = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

  // Keep the divider arithmetic well defined in the excluded cases; their
  // results are overridden below anyway.
  assign safe_rt = (div_zero || div_ovf) ? 32'd1 : rt;
  assign rs_s    = $signed(rs);
  assign rt_s    = $signed(safe_rt);

  // SystemVerilog signed / and % truncate toward zero, remainder takes the
  // sign of the dividend, which is the MIPS definition.
  assign quo_s = rs_s / rt_s;
  assign rem_s = rs_s % rt_s;
  assign quo_u = rs / safe_rt;
  assign rem_u = rs % safe_rt;

  always_comb begin
    res_hi = cur_hi;
    res_lo = cur_lo;
    case (op)
      MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      DIV: begin
        if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else if (!div_zero) begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      DIVU: begin
        if (!div_zero) begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
      default: begin
        res_hi = cur_hi;
        res_lo = cur_lo;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl
// E-stage multiply/divide controller. Owns HI/LO, sequences a fixed-latency
// multiply or divide and raises a stall for D-stage MDU instructions.
// Ports:
//   clk        in  1   system clock
//   reset      in  1   asynchronous active-low reset
//   e_mdu_op   in  4   E-stage MDU op (MDU_NONE when not an MDU op)
//   e_rs,e_rt  in  32  forwarded operands
//   d_uses_md  in  1   D-stage instruction is an MDU op
//   busy       out 1   multiply/divide in flight
//   md_stall   out 1   stall request to the hazard unit
//   hi, lo     out 32  architectural HI/LO
//   md_rdata   out 32  HI for MFHI, LO for MFLO, else 0 (combinational)
// The result is computed at the start edge and parked in pending registers;
// it is committed to HI/LO at the last busy edge, so HI/LO keep their old
// values (and MFHI/MFLO read them) for the whole busy window.
// ---------------------------------------------------------------------------
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_mdu_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        busy_q, busy_d;

  logic        start;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;

  mdu_calc u_calc (
    .op     (e_mdu_op),
    .rs     (e_rs),
    .rt     (e_rt),
    .cur_hi (hi_q),
    .cur_lo (lo_q),
    .res_hi (calc_hi),
    .res_lo (calc_lo)
  );

  assign start = (state_q == ST_IDLE) && is_md_arith(e_mdu_op);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pend_hi_d = calc_hi;
          pend_lo_d = calc_lo;
          cnt_d     = is_md_mult(e_mdu_op) ? MULT_LAT : DIV_LAT;
          state_d   = ST_RUN;
          busy_d    = 1'b1;
        end else if (e_mdu_op == MTHI) begin
          hi_d = e_rs;
        end else if (e_mdu_op == MTLO) begin
          lo_d = e_rs;
        end
      end
      ST_RUN: begin
        // Ops arriving here are protocol violations and are ignored.
        // cnt_q==0 cannot occur; treating it as the last cycle avoids a
        // stuck FSM should it ever be reached.
        if (cnt_q <= 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Stalling on the start cycle too keeps a D-stage MDU op from entering E
  // in the cycle the unit is being claimed.
  assign md_stall = d_uses_md && (busy_q || start);

  always_comb begin
    md_rdata = 32'd0;
    if (e_mdu_op == MFHI) md_rdata = hi_q;
    else if (e_mdu_op == MFLO) md_rdata = lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl. Inputs change just after the falling edge;
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  e_mdu_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        d_uses_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_rdata;

  int total = 0;
  int bad   = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .e_mdu_op  (e_mdu_op),
    .e_rs      (e_rs),
    .e_rt      (e_rt),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .md_stall  (md_stall),
    .hi        (hi),
    .lo        (lo),
    .md_rdata  (md_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance to the next falling edge and drive a new E-stage op.
  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    e_mdu_op = op;
    e_rs     = rs;
    e_rt     = rt;
    #1;
  endtask

  // Start an arithmetic op, count busy cycles (bounded), then check HI/LO.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input int exp_cyc, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    n = 0;
    drive(op, rs, rt);
    for (int i = 0; i < 40; i++) begin
      drive(MDU_NONE, 32'd0, 32'd0);
      if (busy) n++;
      else break;
    end
    chk({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    reset     = 1'b0;
    e_mdu_op  = MDU_NONE;
    e_rs      = 32'd0;
    e_rt      = 32'd0;
    d_uses_md = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", {31'd0, md_stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // MTHI then MFHI
    drive(MTHI, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_rdata", md_rdata, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    drive(MFHI, 32'd0, 32'd0);
    chk("mfhi_rdata", md_rdata, 32'hDEAD_BEEF);
    chk("mfhi_busy", {31'd0, busy}, 32'd0);

    // MULT -2*3 with a D-stage MDU op waiting
    d_uses_md = 1'b1;
    drive(MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_start_stall", {31'd0, md_stall}, 32'd1);
    chk("mult_start_busy", {31'd0, busy}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      drive(MDU_NONE, 32'd0, 32'd0);
      chk($sformatf("mult_busy_c%0d", i), {31'd0, busy}, 32'd1);
      chk($sformatf("mult_stall_c%0d", i), {31'd0, md_stall}, 32'd1);
    end
    drive(MFLO, 32'd0, 32'd0);
    chk("mult_idle_busy", {31'd0, busy}, 32'd0);
    chk("mult_idle_stall", {31'd0, md_stall}, 32'd0);
    chk("mult_mflo", md_rdata, 32'hFFFF_FFFA);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    d_uses_md = 1'b0;

    run_op("multu", MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    // Divide by zero keeps HI/LO
    drive(MTHI, 32'h11, 32'd0);
    drive(MTLO, 32'h22, 32'd0);
    run_op("divu_by0", DIVU, 32'd7, 32'd0, 10, 32'h11, 32'h22);
    run_op("div_by0", DIV, 32'hFFFF_FFF9, 32'd0, 10, 32'h11, 32'h22);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    // MTLO / MFHI during RUN are ignored; MFHI still reads old HI
    drive(DIV, 32'd100, 32'd7);
    drive(MDU_NONE, 32'd0, 32'd0);
    drive(MTLO, 32'd5, 32'd0);
    chk("run_mtlo_rdata", md_rdata, 32'd0);
    drive(MFHI, 32'd0, 32'd0);
    chk("run_mfhi_old", md_rdata, 32'd0);
    chk("run_busy", {31'd0, busy}, 32'd1);
    begin
      int n;
      n = 0;
      for (int i = 0; i < 40; i++) begin
        drive(MDU_NONE, 32'd0, 32'd0);
        if (!busy) break;
        n++;
      end
      chk("run_ignore_cycles_left", 32'(n), 32'd7);
    end
    chk("run_ignore_lo", lo, 32'd14);
    chk("run_ignore_hi", hi, 32'd2);

    // Reset in cycle 3 of a DIV, between clock edges
    drive(DIV, 32'd100, 32'd7);
    drive(MDU_NONE, 32'd0, 32'd0);
    drive(MDU_NONE, 32'd0, 32'd0);
    drive(MDU_NONE, 32'd0, 32'd0);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("mult_4x5", MULT, 32'd4, 32'd5, 5, 32'd0, 32'h14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- E-stage multiply/divide unit controller for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E stage and sequences a fixed-latency multiply or divide.
- Owns the HI/LO registers and supplies mfhi/mflo read data.
- Raises the stall request the hazard unit uses to hold a D-stage HI/LO instruction while the unit is busy.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- e_mdu_op  in  4  E-stage MDU operation code (package constants); MDU_NONE when the instruction is not an MDU op.
- e_rs  in  32  forwarded rs operand.
- e_rt  in  32  forwarded rt operand.
- d_uses_md  in  1  the D-stage instruction is any MDU op.
- busy  out  1  a multiply or divide is in flight.
- md_stall  out  1  stall request to the hazard unit.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- md_rdata  out  32  HI for MFHI, LO for MFLO, else 0; combinational.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, cnt=0, hi=0, lo=0, pending regs=0, busy=0.
- FSM, two states: IDLE and RUN.
- Start of an arithmetic op: in IDLE, e_mdu_op in {MULT, MULTU, DIV, DIVU} at edge T.
  - Operands are evaluated and the 64-bit result is latched into the pending HI/LO registers at edge T.
  - cnt loads MULT_CYCLES or DIV_CYCLES; the FSM goes to RUN.
- RUN:
  - cnt decrements each edge.
  - At the edge where cnt==1: hi/lo take the pending values, cnt becomes 0, and the FSM returns to IDLE.
  - busy=1 in exactly N cycles after the start edge, where N is the op latency.
  - The new hi/lo are visible in the first cycle busy=0.
- Result definitions:
  - MULT: signed 32x32, {hi,lo} = full 64-bit product.
  - MULTU: unsigned 32x32, {hi,lo} = full 64-bit product.
  - DIV: lo = signed quotient, truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: lo = unsigned quotient; hi = unsigned remainder.
  - Divide by zero: the pending values are the current hi/lo, so hi/lo are unchanged; latency is still DIV_CYCLES.
  - 0x80000000 / -1 (DIV): lo=0x80000000, hi=0.
- MTHI/MTLO, only in IDLE:
  - hi (or lo) <= e_rs at the next edge, single cycle, no busy.
  - md_rdata=0 for these ops.
- MFHI/MFLO: md_rdata = current hi/lo in the same cycle, with no internal bypass.
- md_stall = d_uses_md & (busy | start_this_cycle).
  - start_this_cycle = IDLE & e_mdu_op is an arithmetic MDU op.
  - This guarantees the hazard unit keeps any D-stage MDU op out of E until the unit is idle.
- Ops arriving in RUN: any non-NONE e_mdu_op is a protocol violation.
  - It is ignored: no state change and no restart.
  - md_rdata still returns the current (old) hi/lo.
- Reset asserted mid-RUN: the operation is aborted immediately, the pending result is discarded, and hi/lo are zeroed.
- There is no flush input; the pipeline never cancels an E-stage MDU op.

Decomposition:
- Shared package mdu_pkg:
  - 4-bit op codes: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - Predicate functions is_md_arith and is_md_any.
  - The E-stage decoder imports the same constants.
- One sub-module: mdu_calc, a purely combinational 64-bit result generator (op, rs, rt, cur_hi, cur_lo -> res_hi, res_lo), including the divide-by-zero and overflow rules.
- The FSM, counter and HI/LO registers stay in mdu_ctrl.

Test Plan:
- MULT, rs=0xFFFFFFFE (-2), rt=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7, rt=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU rs=7, rt=0 with hi=0x11, lo=0x22 -> after 10 cycles hi=0x11, lo=0x22.
- MTHI rs=0xDEADBEEF, then MFHI next cycle -> md_rdata=0xDEADBEEF; busy never asserts.
- Start MULT with d_uses_md=1 in the same cycle -> md_stall=1 that cycle and for all 5 busy cycles; md_stall=0 in the first idle cycle, when MFLO returns the product low word.
- Drive MTLO 0x5 in cycle 2 of a DIV -> ignored; at completion lo = quotient, not 0x5.
- Assert reset in cycle 3 of a DIV, between clock edges -> busy, hi and lo go to 0 immediately; after release, a new MULT 4*5 gives lo=0x14 after 5 cycles.
